cordic_vector_unit: RTL and testbench
=====================================

Name: cordic_vector_unit

Overview:
- Iterative vectoring-mode CORDIC; the inverse of the rotation-mode sin/cos path.
- Takes a Cartesian vector (X, Y) in Q1.15 and returns its phase and magnitude.
- Phase is in the same 17-bit unsigned phase format the sine/cosine generator consumes, so a result can be fed back to regenerate the vector.
- One shared datapath, one micro-rotation per clock; valid/ready handshake on both input and output.

Parameters:
- STAGES, 16, number of micro-rotations; legal range 8..16.
- ATAN_W, 17, phase width; full turn = 2^ATAN_W counts.

Ports:
- Clk  input  1  clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- In_valid  input  1  X_in/Y_in valid.
- In_ready  output  1  block can accept a vector.
- X_in  input  16  signed Q1.15 X component.
- Y_in  input  16  signed Q1.15 Y component.
- Out_valid  output  1  Angle_out/Mag_out valid.
- Out_ready  input  1  consumer accepts result.
- Angle_out  output  17  unsigned phase [0, 2^17): 0x08000 = pi/2, 0x10000 = pi.
- Mag_out  output  18  unsigned Q3.15 magnitude.

Behaviour:
- Reset (synchronous, active-high): state IDLE, In_ready=1, Out_valid=0, Angle_out=0, Mag_out=0, iteration counter=0. Reset mid-iteration or in DONE abandons the operation; no result is emitted.
- FSM: IDLE -> ITER -> DONE -> IDLE.
- IDLE:
  - In_ready=1.
  - On In_valid&&In_ready, load 18-bit signed x, y registers with sign-extended inputs and apply quadrant pre-rotation.
  - If X_in<0: x=-X_in, y=-Y_in, z=0x10000. Else: x=X_in, y=Y_in, z=0.
  - 18-bit width makes negation of -32768 exact.
  - Go to ITER with i=0.
- ITER:
  - In_ready=0. One micro-rotation per cycle.
  - If y>=0: x+=y>>>i; y-=x>>>i; z+=ATAN[i].
  - Else: x-=y>>>i; y+=x>>>i; z-=ATAN[i].
  - Shifts are arithmetic on the old register values.
  - z is modulo 2^17: wrap-around is intended, no saturation.
  - ATAN[i] = round(atan(2^-i) * 2^17 / (2*pi)); ATAN[0]=0x4000, ATAN[1]=0x25C8, ATAN[2]=0x13F6.
  - After i=STAGES-1, register outputs and go to DONE.
- DONE output formation:
  - Angle_out = z[16:0].
  - Mag_out per the Optional Feature.
  - If X_in==0 and Y_in==0 (flag captured at load), force Angle_out=0 and Mag_out=0.
- DONE handshake:
  - Out_valid=1; outputs held stable while Out_ready=0.
  - On Out_valid&&Out_ready, go to IDLE; Out_valid=0 and In_ready=1 on the next cycle.
  - No overlap of operations.
- Latency: acceptance edge T -> Out_valid high after edge T+STAGES.
- Throughput: one vector per STAGES+2 cycles with Out_ready held high.
- Accuracy at STAGES=16: Angle_out within +/-4 counts of ideal (mod 2^17); Mag_out within +/-4 LSB.

Optional Feature:
- Macro: CORDIC_VECTOR_GAIN_COMP_EN.
- Defined: Mag_out = (x_final * 16'sh4DB9 + 2^14) >>> 15, i.e. CORDIC gain removed, true magnitude, max ~1.414.
  - Multiply is registered in the ITER->DONE transition; latency is unchanged.
- Undefined: no multiplier; Mag_out = x_final, i.e. magnitude * ~1.6468, max ~2.33, fits Q3.15.

Test Plan:
- (X,Y)=(0x4000,0x0000) -> Angle_out=0x00000 +/-4; Mag_out=0x04000 (comp) or ~0x0696A (no comp), +/-4; Out_valid exactly STAGES cycles after acceptance edge.
- Axis and quadrant vectors:
  - (0x0000,0x4000) -> 0x08000.
  - (-0x4000,0x0000) -> 0x10000.
  - (0x0000,-0x4000) -> 0x18000.
  - (0x2D41,0x2D41) -> 0x04000, Mag 0x4000.
  - All +/-4.
- Corner and wrap cases:
  - (-0x8000,-0x8000) -> angle 0x14000, Mag ~0xB505 (comp), no overflow.
  - (0x4000,-0x0001) -> angle near 0x1FFFF/0x00000 (mod-2^17 wrap), within tolerance.
- (0,0) -> Angle_out=0, Mag_out=0.
- Backpressure:
  - Out_ready low for 10 cycles in DONE: outputs and Out_valid stable, In_ready=0, new In_valid ignored.
  - Out_ready high: Out_valid drops, In_ready rises the next cycle.
- Reset asserted at ITER i=5:
  - Next cycle: In_ready=1, Out_valid=0, outputs 0.
  - Subsequent vector (0x2D41,0x2D41) completes correctly.

Source files
------------

// File: rtl/cordic_vector_unit_if.sv
// rtl/cordic_vector_unit_if.sv - vector in / phase+magnitude out handshake bundle
//
// Purpose: groups the two valid/ready channels of cordic_vector_unit.
// Ports (signals):
//   in_valid, in_ready        input-channel handshake
//   x_in, y_in                signed Q1.15 vector components
//   out_valid, out_ready      result-channel handshake
//   angle_out                 unsigned phase, full turn = 2^ATAN_W
//   mag_out                   unsigned Q3.15 magnitude
// Modports: master = producer of vectors / consumer of results,
//           slave  = the CORDIC unit.
interface cordic_vector_unit_if #(
  parameter int ATAN_W = 17
);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       x_in;
  logic [15:0]       y_in;
  logic              out_valid;
  logic              out_ready;
  logic [ATAN_W-1:0] angle_out;
  logic [17:0]       mag_out;

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, angle_out, mag_out
  );

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, angle_out, mag_out
  );
endinterface

// File: rtl/cordic_vector_unit.sv
// rtl/cordic_vector_unit.sv - iterative vectoring-mode CORDIC (phase and magnitude)
//
// Purpose: converts a Q1.15 Cartesian vector to a 17-bit unsigned phase
// (0x08000 = pi/2) and an 18-bit Q3.15 magnitude, one micro-rotation per clock.
// Ports:
//   clk_i   clock, rising edge
//   rst_i   synchronous active-high reset
//   bus     cordic_vector_unit_if.slave (input and result handshakes)
// Build option: CORDIC_VECTOR_GAIN_COMP_EN - when defined the CORDIC gain is
//   removed from the magnitude with a single constant multiply; otherwise the
//   magnitude carries the ~1.6468 gain.
// Note: the arctangent table is scaled for ATAN_W = 17.
module cordic_vector_unit #(
  parameter int STAGES = 16,
  parameter int ATAN_W = 17
) (
  input logic                  clk_i,
  input logic                  rst_i,
  cordic_vector_unit_if.slave  bus
);

  localparam int IW = $clog2(STAGES);
  localparam logic [ATAN_W-1:0] HALF_TURN = ATAN_W'(1) << (ATAN_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q;
  logic signed [17:0]   x_q, y_q;
  logic [ATAN_W-1:0]    z_q;
  logic [IW-1:0]        i_q;
  logic                 zero_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [ATAN_W-1:0]    angle_q;
  logic [17:0]          mag_q;

  // round(atan(2^-i) * 2^17 / (2*pi))
  function automatic logic [ATAN_W-1:0] atan_lut(input int idx);
    logic [16:0] v;
    case (idx)
      0:       v = 17'h04000;
      1:       v = 17'h025C8;
      2:       v = 17'h013F6;
      3:       v = 17'h00A22;
      4:       v = 17'h00516;
      5:       v = 17'h0028C;
      6:       v = 17'h00146;
      7:       v = 17'h000A3;
      8:       v = 17'h00051;
      9:       v = 17'h00029;
      10:      v = 17'h00014;
      11:      v = 17'h0000A;
      12:      v = 17'h00005;
      13:      v = 17'h00003;
      14:      v = 17'h00001;
      15:      v = 17'h00001;
      default: v = 17'h00000;
    endcase
    return ATAN_W'(v);
  endfunction

  // Sign-extended inputs; 18 bits keep -(-32768) representable.
  logic signed [17:0] x_ext, y_ext;
  assign x_ext = {{2{bus.x_in[15]}}, bus.x_in};
  assign y_ext = {{2{bus.y_in[15]}}, bus.y_in};

  // One micro-rotation on the current register values.
  logic signed [17:0] x_sh, y_sh, x_nx, y_nx;
  logic [ATAN_W-1:0]  z_nx;
  logic [ATAN_W-1:0]  atan_i;

  always_comb begin
    x_sh   = x_q >>> i_q;
    y_sh   = y_q >>> i_q;
    atan_i = atan_lut(int'(i_q));
    if (!y_q[17]) begin
      x_nx = x_q + y_sh;
      y_nx = y_q - x_sh;
      z_nx = z_q + atan_i;
    end else begin
      x_nx = x_q - y_sh;
      y_nx = y_q + x_sh;
      z_nx = z_q - atan_i;
    end
  end

  // Magnitude formed from the last rotation's x, registered on entry to DONE.
  logic [17:0] mag_nx;
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
  logic signed [33:0] prod;
  always_comb begin
    // 0x4DB9 / 2^15 ~= 1/K for 16 stages; +2^14 rounds to nearest.
    prod   = 34'(x_nx) * 34'sh4DB9 + 34'sd16384;
    mag_nx = prod[32:15];
  end
`else
  assign mag_nx = x_nx;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      i_q         <= '0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      angle_q     <= '0;
      mag_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            // Fold the left half-plane onto the right so the iterations
            // only need to cover +/- pi/2.
            if (bus.x_in[15]) begin
              x_q <= -x_ext;
              y_q <= -y_ext;
              z_q <= HALF_TURN;
            end else begin
              x_q <= x_ext;
              y_q <= y_ext;
              z_q <= '0;
            end
            zero_q     <= (bus.x_in == 16'd0) && (bus.y_in == 16'd0);
            i_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ITER;
          end
        end
        ITER: begin
          x_q <= x_nx;
          y_q <= y_nx;
          z_q <= z_nx;
          if (i_q == IW'(STAGES - 1)) begin
            angle_q     <= zero_q ? '0 : z_nx;
            mag_q       <= zero_q ? '0 : mag_nx;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            i_q <= i_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.angle_out = angle_q;
  assign bus.mag_out   = mag_q;

endmodule

// File: tb/tb_cordic_vector_unit.sv
// tb/tb_cordic_vector_unit.sv - self-checking bench for cordic_vector_unit
module tb_cordic_vector_unit;
  localparam int STAGES = 16;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cordic_vector_unit_if bus_if ();

  cordic_vector_unit #(.STAGES(STAGES), .ATAN_W(17)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  int  total = 0;
  int  bad   = 0;
  real gain;
  int  mag_tol;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    int          exp_angle;
    int          exp_mag;   // true magnitude in LSB, gain applied at run time
    bit          is_zero;
  } vec_t;

  vec_t tbl[9];

  task automatic check_val(input string name, input int act, input int exp, input int tol);
    total++;
    if (act - exp > tol || exp - act > tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (+/-%0d)", name, act, exp, tol);
    end
  endtask

  task automatic check_angle(input string name, input int act, input int exp, input int tol);
    int d;
    d = (act - exp) & 32'h1FFFF;
    if (d >= 65536) d -= 131072;
    total++;
    if (d > tol || d < -tol) begin
      bad++;
      $display("FAIL %s: got 0x%05h want 0x%05h (+/-%0d mod 2^17)", name, act, exp, tol);
    end
  endtask

  // Ideal phase in counts, reduced to [0, 2^17).
  function automatic int model_angle(input int xs, input int ys);
    real a;
    int  c;
    a = $atan2(real'(ys), real'(xs)) / (2.0 * PI) * 131072.0;
    c = int'(a);
    if (c < 0) c += 131072;
    return c & 32'h1FFFF;
  endfunction

  function automatic int model_mag(input int xs, input int ys);
    return int'($sqrt(real'(xs) * real'(xs) + real'(ys) * real'(ys)) * gain);
  endfunction

  // Called #1 after a rising edge; returns with the result consumed.
  task automatic run_vec(input logic [15:0] xi, input logic [15:0] yi,
                         output int ang, output int mag, output int lat);
    int guard;
    guard = 0;
    while (!bus_if.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) begin
      total++; bad++;
      $display("FAIL in_ready_wait: got timeout want in_ready=1");
    end
    bus_if.x_in     = xi;
    bus_if.y_in     = yi;
    bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    lat = 0;
    while (!bus_if.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    ang = int'(bus_if.angle_out);
    mag = int'(bus_if.mag_out);
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
  endtask

  initial begin
    int ang, mag, lat;
    int xs, ys;
    logic [15:0] xr, yr;
    int hold_ang, hold_mag;
    int acc_cyc[$];

    gain = 1.0;
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
    mag_tol = 4;
`else
    for (int i = 0; i < STAGES; i++) gain = gain * $sqrt(1.0 + 2.0 ** (-2.0 * i));
    mag_tol = 8;
`endif

    tbl[0] = '{16'h4000, 16'h0000, 32'h00000, 16384, 1'b0};
    tbl[1] = '{16'h0000, 16'h4000, 32'h08000, 16384, 1'b0};
    tbl[2] = '{16'hC000, 16'h0000, 32'h10000, 16384, 1'b0};
    tbl[3] = '{16'h0000, 16'hC000, 32'h18000, 16384, 1'b0};
    tbl[4] = '{16'h2D41, 16'h2D41, 32'h04000, 16384, 1'b0};
    tbl[5] = '{16'h8000, 16'h8000, 32'h14000, 46341, 1'b0};
    tbl[6] = '{16'h4000, 16'hFFFF, 32'h1FFFF, 16384, 1'b0};
    tbl[7] = '{16'h0000, 16'h0000, 32'h00000, 0,     1'b1};
    tbl[8] = '{16'h7FFF, 16'h7FFF, 32'h04000, 46339, 1'b0};

    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    bus_if.x_in      = '0;
    bus_if.y_in      = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_val("reset_in_ready",  int'(bus_if.in_ready),  1, 0);
    check_val("reset_out_valid", int'(bus_if.out_valid), 0, 0);
    check_val("reset_angle",     int'(bus_if.angle_out), 0, 0);
    check_val("reset_mag",       int'(bus_if.mag_out),   0, 0);

    // Directed table.
    foreach (tbl[k]) begin
      run_vec(tbl[k].x, tbl[k].y, ang, mag, lat);
      check_val($sformatf("latency[%0d]", k), lat, STAGES, 0);
      if (tbl[k].is_zero) begin
        check_val($sformatf("angle[%0d]", k), ang, 0, 0);
        check_val($sformatf("mag[%0d]", k), mag, 0, 0);
      end else begin
        check_angle($sformatf("angle[%0d]", k), ang, tbl[k].exp_angle, 4);
        check_val($sformatf("mag[%0d]", k), mag, int'(real'(tbl[k].exp_mag) * gain), mag_tol);
      end
    end

    // Random vectors against the floating-point model.
    for (int n = 0; n < 40; n++) begin
      do begin
        xr = 16'($urandom_range(0, 65535));
        yr = 16'($urandom_range(0, 65535));
        xs = int'($signed(xr));
        ys = int'($signed(yr));
      end while (xs * xs + ys * ys < 16384 * 16384);
      run_vec(xr, yr, ang, mag, lat);
      check_angle($sformatf("rand_angle[%0d] x=%0d y=%0d", n, xs, ys), ang, model_angle(xs, ys), 6);
      check_val($sformatf("rand_mag[%0d] x=%0d y=%0d", n, xs, ys), mag, model_mag(xs, ys), mag_tol + 2);
    end

    // Backpressure: hold result for 10 cycles while a new vector is offered.
    bus_if.x_in = 16'h2D41; bus_if.y_in = 16'h2D41; bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.x_in = 16'h4000; bus_if.y_in = 16'h0000;
    lat = 0;
    while (!bus_if.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check_val("bp_latency", lat, STAGES, 0);
    hold_ang = int'(bus_if.angle_out);
    hold_mag = int'(bus_if.mag_out);
    check_angle("bp_angle", hold_ang, 32'h04000, 4);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check_val($sformatf("bp_out_valid[%0d]", c), int'(bus_if.out_valid), 1, 0);
      check_val($sformatf("bp_in_ready[%0d]", c),  int'(bus_if.in_ready),  0, 0);
      check_val($sformatf("bp_angle_hold[%0d]", c), int'(bus_if.angle_out), hold_ang, 0);
      check_val($sformatf("bp_mag_hold[%0d]", c),   int'(bus_if.mag_out),   hold_mag, 0);
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
    check_val("bp_release_out_valid", int'(bus_if.out_valid), 0, 0);
    check_val("bp_release_in_ready",  int'(bus_if.in_ready),  1, 0);

    // Reset while the iteration counter reads 5.
    bus_if.x_in = 16'h4000; bus_if.y_in = 16'h4000; bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("midrst_in_ready",  int'(bus_if.in_ready),  1, 0);
    check_val("midrst_out_valid", int'(bus_if.out_valid), 0, 0);
    check_val("midrst_angle",     int'(bus_if.angle_out), 0, 0);
    check_val("midrst_mag",       int'(bus_if.mag_out),   0, 0);
    lat = 0;
    for (int c = 0; c < STAGES + 4; c++) begin
      @(posedge clk); #1;
      if (bus_if.out_valid) lat++;
    end
    check_val("midrst_no_result", lat, 0, 0);
    run_vec(16'h2D41, 16'h2D41, ang, mag, lat);
    check_val("post_rst_latency", lat, STAGES, 0);
    check_angle("post_rst_angle", ang, 32'h04000, 4);
    check_val("post_rst_mag", mag, int'(16384.0 * gain), mag_tol);

    // Throughput with both sides always willing.
    bus_if.x_in = 16'h1000; bus_if.y_in = 16'h2000;
    bus_if.in_valid = 1'b1; bus_if.out_ready = 1'b1;
    for (int c = 0; c < 3 * (STAGES + 2); c++) begin
      if (bus_if.in_valid && bus_if.in_ready) acc_cyc.push_back(c);
      @(posedge clk); #1;
    end
    bus_if.in_valid = 1'b0;
    if (acc_cyc.size() >= 2) begin
      check_val("throughput_interval", acc_cyc[1] - acc_cyc[0], STAGES + 2, 0);
    end else begin
      check_val("throughput_accepts", acc_cyc.size(), 2, 0);
    end
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
